// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segment order is bit0=a .. bit6=g, active-low (0 lights a segment).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low glyphs for hex digits 0..F
  localparam seg_t SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg7_hex_digit.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_digit
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  // Table lookup of the glyph for one nibble
  always_comb begin
    seg = SEG_HEX[nib];
  end

endmodule

// File: rtl/seg7_multi_display.sv
// Registered N-digit hex driver for a seven-segment bank.
// Captures nibbles/enable/blink masks on ld, decodes each digit, and applies
// per-digit enable and blink blanking. The blink phase comes from a free-running
// prescaler that toggles blink_on every BLINK_DIV clocks.
// Optional feature: define SEG7_LZB_EN to blank leading zero digits (digit 0 is
// always kept so a zero value still shows "0").
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld,
  input  logic [4*N_DIGITS-1:0]   val,
  input  logic [N_DIGITS-1:0]     en_mask,
  input  logic [N_DIGITS-1:0]     blink_mask,
  output logic [7*N_DIGITS-1:0]   hex,
  output logic                    blink_on
);

  localparam int             CNT_W    = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [4*N_DIGITS-1:0] val_r;
  logic [N_DIGITS-1:0]   en_r;
  logic [N_DIGITS-1:0]   blk_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  blink_on_r;
  logic [7*N_DIGITS-1:0] hex_r;
  logic [7*N_DIGITS-1:0] hex_nxt_s;
  logic [N_DIGITS-1:0]   blank_s;
  seg_t                  dig_seg_s [N_DIGITS];

  // Capture registers: load on ld, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r <= '0;
      en_r  <= '0;
      blk_r <= '0;
    end else if (ld) begin
      val_r <= val;
      en_r  <= en_mask;
      blk_r <= blink_mask;
    end
  end

  // Free-running blink prescaler; toggles phase on wrap, independent of ld
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      blink_on_r <= 1'b1;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r      <= '0;
      blink_on_r <= ~blink_on_r;
    end else begin
      cnt_r      <= cnt_r + CNT_W'(1);
      blink_on_r <= blink_on_r;
    end
  end

  // One glyph decoder per digit, fed from the captured nibbles
  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_dig
      seg7_hex_digit u_dig (
        .nib (val_r[4*g +: 4]),
        .seg (dig_seg_s[g])
      );
    end
  endgenerate

`ifdef SEG7_LZB_EN
  logic [N_DIGITS-1:0] lz_keep_s;
  logic                lz_seen_s;

  // Scan from the top digit down; keep a digit once a nonzero nibble is seen
  always_comb begin
    lz_seen_s = 1'b0;
    lz_keep_s = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_seen_s    = lz_seen_s | (val_r[4*i +: 4] != 4'h0);
      lz_keep_s[i] = lz_seen_s | (i == 0);
    end
  end
`endif

  // Per-digit blanking: disabled digit, or blinking digit in the off-phase
  always_comb begin
    blank_s = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
`ifdef SEG7_LZB_EN
      blank_s[i] = ~en_r[i] | (blk_r[i] & ~blink_on_r) | ~lz_keep_s[i];
`else
      blank_s[i] = ~en_r[i] | (blk_r[i] & ~blink_on_r);
`endif
    end
  end

  // Assemble the next segment word from glyphs and blanking
  always_comb begin
    hex_nxt_s = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (blank_s[i]) begin
        hex_nxt_s[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_nxt_s[7*i +: 7] = dig_seg_s[i];
      end
    end
  end

  // Output register; dark while in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_r <= '1;
    end else begin
      hex_r <= hex_nxt_s;
    end
  end

  assign hex      = hex_r;
  assign blink_on = blink_on_r;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed bench for seg7_multi_display with N_DIGITS=4, BLINK_DIV=4.
// Build with +define+SEG7_LZB_EN to exercise leading-zero blanking.
module tb_seg7_multi_display;

  localparam int N   = 4;
  localparam int DIV = 4;

`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [27:0] DARK = 28'hFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic [15:0] val;
  logic [3:0]  en_mask;
  logic [3:0]  blink_mask;
  logic [27:0] hex;
  logic        blink_on;

  int errors = 0;
  int checks = 0;

  // Independent prescaler model: edges since reset
  int   m_cnt;
  logic m_blink;
  logic m_prev;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  e;
    logic [27:0] x;
  } vec_t;

  vec_t tbl [7];

  seg7_multi_display #(.N_DIGITS(N), .BLINK_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld),
    .val        (val),
    .en_mask    (en_mask),
    .blink_mask (blink_mask),
    .hex        (hex),
    .blink_on   (blink_on)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    m_prev = m_blink;
    if (rst) begin
      m_cnt   = 0;
      m_blink = 1'b1;
    end else if (m_cnt == DIV - 1) begin
      m_cnt   = 0;
      m_blink = ~m_blink;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [27:0] prev_x;
    logic [27:0] on_x;
    logic [27:0] off_x;
    logic        found;

    tbl[0] = '{16'h0A81, 4'hF, LZB ? {7'h7F, 7'h08, 7'h00, 7'h79} : {7'h40, 7'h08, 7'h00, 7'h79}};
    tbl[1] = '{16'h1234, 4'b0101, {7'h7F, 7'h24, 7'h7F, 7'h19}};
    tbl[2] = '{16'h0000, 4'hF, LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[3] = '{16'h0100, 4'hF, LZB ? {7'h7F, 7'h79, 7'h40, 7'h40} : {7'h40, 7'h79, 7'h40, 7'h40}};
    tbl[4] = '{16'hFEDC, 4'hF, {7'h0E, 7'h06, 7'h21, 7'h46}};
    tbl[5] = '{16'h9765, 4'hF, {7'h10, 7'h78, 7'h02, 7'h12}};
    tbl[6] = '{16'h0B00, 4'hF, LZB ? {7'h7F, 7'h03, 7'h40, 7'h40} : {7'h40, 7'h03, 7'h40, 7'h40}};

    rst = 1'b1; ld = 1'b0; val = 16'h0; en_mask = 4'h0; blink_mask = 4'h0;
    m_cnt = 0; m_blink = 1'b1; m_prev = 1'b1;

    // Reset for two cycles
    step();
    step();
    check("reset_hex", hex, DARK);
    check("reset_blink", {27'b0, blink_on}, 28'h1);
    rst = 1'b0;
    step();
    check("idle_hex_1", hex, DARK);
    step();
    check("idle_hex_2", hex, DARK);

    // Table: load, check latency, value, then hold
    prev_x = DARK;
    for (int k = 0; k < 7; k++) begin
      val = tbl[k].v; en_mask = tbl[k].e; blink_mask = 4'h0; ld = 1'b1;
      step();
      ld = 1'b0;
      val = 16'hFFFF; en_mask = 4'h0;
      check($sformatf("latency_%0d", k), hex, prev_x);
      step();
      check($sformatf("load_%0d", k), hex, tbl[k].x);
      step();
      check($sformatf("hold_%0d", k), hex, tbl[k].x);
      prev_x = tbl[k].x;
    end

    // Blink: digit0 blinks, lagging blink_on by one clock
    rst = 1'b1;
    step();
    rst = 1'b0;
    val = 16'h0008; en_mask = 4'hF; blink_mask = 4'b0001; ld = 1'b1;
    step();
    ld = 1'b0;
    on_x  = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h00} : {7'h40, 7'h40, 7'h40, 7'h00};
    off_x = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h7F} : {7'h40, 7'h40, 7'h40, 7'h7F};
    for (int t = 0; t < 12; t++) begin
      step();
      check($sformatf("blink_phase_%0d", t), {27'b0, blink_on}, {27'b0, m_blink});
      check($sformatf("blink_hex_%0d", t), hex, m_prev ? on_x : off_x);
    end

    // Collision: ld on the wrap edge during the on-phase
    found = 1'b0;
    for (int t = 0; t < 16; t++) begin
      if (m_cnt == DIV - 1 && m_blink == 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("coll_sync", {27'b0, found}, 28'h1);
    val = 16'h0F50; en_mask = 4'hF; blink_mask = 4'b0100; ld = 1'b1;
    step();
    ld = 1'b0;
    check("coll_toggle", {27'b0, blink_on}, 28'h0);
    check("coll_old_hex", hex, on_x);
    step();
    check("coll_new_hex", hex, LZB ? {7'h7F, 7'h7F, 7'h12, 7'h40} : {7'h40, 7'h7F, 7'h12, 7'h40});
    check("coll_phase", {27'b0, blink_on}, 28'h0);

    // Reset mid-run in the on-phase with the prescaler part way through
    found = 1'b0;
    for (int t = 0; t < 16; t++) begin
      if (m_cnt == 2 && m_blink == 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("rst_sync", {27'b0, found}, 28'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_blink", {27'b0, blink_on}, 28'h1);
    check("rst_mid_hex", hex, DARK);
    step();
    check("rst_next_hex", hex, DARK);
    step();
    check("rst_cnt_2", {27'b0, blink_on}, 28'h1);
    step();
    check("rst_cnt_3", {27'b0, blink_on}, 28'h1);
    step();
    check("rst_cnt_wrap", {27'b0, blink_on}, 28'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
